// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline stall/flush controller.
// Covers the default stage count, stage indices and the fetch-drop FSM encoding.
package pipe_ctrl_pkg;
  localparam int NSTG_DEF     = 6;
  localparam int CNT_W_DEF    = 32;
  localparam int HANG_CYC_DEF = 1024;

  // Stage indices for the default 6-stage arrangement; WB is always the oldest.
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = NSTG_DEF - 1;

  typedef enum logic {
    IDLE = 1'b0,
    DROP = 1'b1
  } fetch_st_e;
endpackage

// File: rtl/pipe_ctrl_n_if.sv
// Control bundle between the pipeline, the exception unit and the stall/flush controller.
// The slave modport is the controller itself.
interface pipe_ctrl_n_if
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTG  = NSTG_DEF,
  parameter int CNT_W = CNT_W_DEF
);
  logic [NSTG-1:0]  stallreq_i;
  logic [NSTG-1:0]  redir_req_i;
  logic [NSTG-1:0]  redir_ack_o;
  logic             excp_flush_i;
  logic             if_busy_i;
  logic [NSTG-1:0]  stall_o;
  logic [NSTG-2:0]  flush_o;
  logic             drop_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic             hang_o;
  logic             hang_clr_i;

  modport master (
    output stallreq_i, redir_req_i, excp_flush_i, if_busy_i, hang_clr_i,
    input  redir_ack_o, stall_o, flush_o, drop_o, stall_cnt_o, hang_o
  );

  modport slave (
    input  stallreq_i, redir_req_i, excp_flush_i, if_busy_i, hang_clr_i,
    output redir_ack_o, stall_o, flush_o, drop_o, stall_cnt_o, hang_o
  );
endinterface

// File: rtl/pipe_ctrl_n_prio_arb.sv
// Highest-index-wins one-hot arbiter.
// mask[i] is set when any request at index >= i is present.
module pipe_prio_arb #(
  parameter int N = 6
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [N-1:0] mask
);
  always_comb begin
    gnt       = '0;
    mask      = '0;
    gnt[N-1]  = req[N-1];
    mask[N-1] = req[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      gnt[i]  = req[i] & ~mask[i+1];
      mask[i] = req[i] | mask[i+1];
    end
  end
endmodule

// File: rtl/pipe_ctrl_n.sv
// Generic pipeline stall/flush controller: stall mask, oldest-wins redirect,
// fetch-drop FSM, saturating stall counter and stall-hang watchdog.
module pipe_ctrl_n
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTG     = NSTG_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  parameter int HANG_CYC = HANG_CYC_DEF
) (
  input logic          clk,
  input logic          rst,
  pipe_ctrl_n_if.slave bus
);
  localparam int              WD_W   = $clog2(HANG_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(HANG_CYC - 1);

  logic [NSTG-1:0]  stall;
  logic [NSTG-1:0]  elig;
  logic [NSTG-1:0]  grant;
  logic [NSTG-1:0]  emask;
  logic [NSTG-1:0]  ack;
  logic [NSTG-2:0]  flush;
  logic             redir_hit;
  logic             drop;
  fetch_st_e        st;
  logic [CNT_W-1:0] stall_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             hang;

  always_comb begin
    stall         = '0;
    stall[NSTG-1] = bus.stallreq_i[NSTG-1];
    for (int j = NSTG - 2; j >= 0; j--)
      stall[j] = bus.stallreq_i[j] | stall[j+1];
  end

  // A request is blocked by any stall raised strictly older than itself.
  assign elig = bus.redir_req_i & ~{1'b0, stall[NSTG-1:1]};

  pipe_prio_arb #(.N(NSTG)) u_redir_arb (
    .req  (elig),
    .gnt  (grant),
    .mask (emask)
  );

  assign ack       = bus.excp_flush_i ? '0 : grant;
  assign redir_hit = emask[0] & ~bus.excp_flush_i;

  // Reset masks the drop state so no drop cycle leaks out while rst is high.
  assign drop = (st == DROP) & ~rst;

  // emask[j+1] is set exactly when the winner sits above boundary j.
  always_comb begin
    flush    = bus.excp_flush_i ? '1 : emask[NSTG-1:1];
    flush[0] = flush[0] | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else begin
      case (st)
        IDLE:    if ((redir_hit || bus.excp_flush_i) && bus.if_busy_i) st <= DROP;
        DROP:    if (!bus.if_busy_i) st <= IDLE;
        default: st <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt <= '0;
    else if (stall[0] && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || bus.hang_clr_i) begin
      wd_cnt <= '0;
      hang   <= 1'b0;
    end else if (|stall) begin
      if (wd_cnt == WD_MAX) hang <= 1'b1;
      else wd_cnt <= wd_cnt + WD_W'(1);
    end else begin
      wd_cnt <= '0;
    end
  end

  assign bus.stall_o     = stall;
  assign bus.redir_ack_o = ack;
  assign bus.flush_o     = flush;
  assign bus.drop_o      = drop;
  assign bus.stall_cnt_o = stall_cnt;
  assign bus.hang_o      = hang;
endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Scoreboard bench for pipe_ctrl_n (NSTG=6, CNT_W=4, HANG_CYC=8): the driver queues
// hand-computed expectations per cycle, a monitor pops and compares on the falling edge.
module tb_pipe_ctrl_n;
  localparam logic [5:0] CA = 6'h3f;

  typedef struct {
    string      nm;
    logic [5:0] s;
    logic [5:0] a;
    logic [4:0] f;
    logic       d;
    logic [3:0] c;
    logic       h;
    logic [5:0] chk;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t q[$];

  pipe_ctrl_n_if #(.NSTG(6), .CNT_W(4)) bus ();

  pipe_ctrl_n #(.NSTG(6), .CNT_W(4), .HANG_CYC(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %b expected %b", nm, fld, act, exp);
    end
  endtask

  task automatic step(input string nm, input bit r, input logic [5:0] sreq, input logic [5:0] rreq,
                      input bit ex, input bit busy, input bit clr,
                      input logic [5:0] es, input logic [5:0] ea, input logic [4:0] ef,
                      input bit ed, input logic [3:0] ec, input bit eh, input logic [5:0] chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst              = r;
    bus.stallreq_i   = sreq;
    bus.redir_req_i  = rreq;
    bus.excp_flush_i = ex;
    bus.if_busy_i    = busy;
    bus.hang_clr_i   = clr;
    e.nm = nm; e.s = es; e.a = ea; e.f = ef; e.d = ed; e.c = ec; e.h = eh; e.chk = chk;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk[0]) cmp(e.nm, "stall", {2'b0, bus.stall_o}, {2'b0, e.s});
        if (e.chk[1]) cmp(e.nm, "ack", {2'b0, bus.redir_ack_o}, {2'b0, e.a});
        if (e.chk[2]) cmp(e.nm, "flush", {3'b0, bus.flush_o}, {3'b0, e.f});
        if (e.chk[3]) cmp(e.nm, "drop", {7'b0, bus.drop_o}, {7'b0, e.d});
        if (e.chk[4]) cmp(e.nm, "cnt", {4'b0, bus.stall_cnt_o}, {4'b0, e.c});
        if (e.chk[5]) cmp(e.nm, "hang", {7'b0, bus.hang_o}, {7'b0, e.h});
      end
    end
  end

  initial begin : driver
    bus.stallreq_i   = '0;
    bus.redir_req_i  = '0;
    bus.excp_flush_i = 1'b0;
    bus.if_busy_i    = 1'b0;
    bus.hang_clr_i   = 1'b0;
    repeat (2) @(posedge clk);

    //    name        rst sreq       rreq       ex busy clr  stall      ack        flush     drp cnt hang
    step("reset_in",   1, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 0,  0, CA);
    step("reset_out",  0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 0,  0, CA);
    step("stall_a",    0, 6'b000100, 6'b000000, 0, 0, 0,   6'b000111, 6'b000000, 5'b00000, 0, 0,  0, CA);
    step("stall_b",    0, 6'b010001, 6'b000000, 0, 0, 0,   6'b011111, 6'b000000, 5'b00000, 0, 1,  0, CA);
    step("stall_off",  0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 2,  0, CA);
    step("redir_arb",  0, 6'b000000, 6'b000110, 0, 0, 0,   6'b000000, 6'b000100, 5'b00011, 0, 2,  0, CA);
    step("redir_blk",  0, 6'b001000, 6'b000110, 0, 0, 0,   6'b001111, 6'b000000, 5'b00000, 0, 2,  0, CA);
    step("redir_rel",  0, 6'b000000, 6'b000110, 0, 0, 0,   6'b000000, 6'b000100, 5'b00011, 0, 3,  0, CA);
    step("excp",       0, 6'b000000, 6'b000100, 1, 0, 0,   6'b000000, 6'b000000, 5'b11111, 0, 3,  0, CA);
    step("excp_after", 0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 3,  0, CA);
    step("excp_stall", 0, 6'b000010, 6'b000000, 1, 0, 0,   6'b000011, 6'b000000, 5'b11111, 0, 3,  0, CA);
    step("excp_idle",  0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 4,  0, CA);
    // fetch drop: ack at t with the bus busy through t+3
    step("drop_t0",    0, 6'b000000, 6'b001000, 0, 1, 0,   6'b000000, 6'b001000, 5'b00111, 0, 4,  0, CA);
    step("drop_t1",    0, 6'b000000, 6'b000000, 0, 1, 0,   6'b000000, 6'b000000, 5'b00001, 1, 4,  0, CA);
    step("drop_t2",    0, 6'b000000, 6'b000000, 0, 1, 0,   6'b000000, 6'b000000, 5'b00001, 1, 4,  0, CA);
    step("drop_t3",    0, 6'b000000, 6'b010000, 0, 1, 0,   6'b000000, 6'b010000, 5'b01111, 1, 4,  0, CA);
    step("drop_t4",    0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00001, 1, 4,  0, CA);
    step("drop_t5",    0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 4,  0, CA);
    // second run: reset lands mid-drop
    step("rdrop_t0",   0, 6'b000000, 6'b000100, 0, 1, 0,   6'b000000, 6'b000100, 5'b00011, 0, 4,  0, CA);
    step("rdrop_t1",   0, 6'b000000, 6'b000000, 0, 1, 0,   6'b000000, 6'b000000, 5'b00001, 1, 4,  0, CA);
    step("rdrop_t2",   1, 6'b000000, 6'b000000, 0, 1, 0,   6'b000000, 6'b000000, 5'b00000, 0, 4,  0, CA);
    step("rdrop_t3",   0, 6'b000000, 6'b000000, 0, 1, 0,   6'b000000, 6'b000000, 5'b00000, 0, 0,  0, CA);
    step("rdrop_t4",   0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 0,  0, CA);

    // 10 stalled cycles: counter reaches 10, watchdog trips on the 8th edge
    for (int i = 1; i <= 10; i++)
      step("cnt_run",  0, 6'b000001, 6'b000000, 0, 0, 0,   6'b000001, 6'b000000, 5'b00000, 0, 4'(i - 1), (i >= 9), CA);
    step("cnt_10",     0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 10, 1, CA);
    step("hang_clr",   0, 6'b000000, 6'b000000, 0, 0, 1,   6'b000000, 6'b000000, 5'b00000, 0, 10, 1, CA);
    step("hang_gone",  0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 10, 0, CA);
    for (int i = 1; i <= 10; i++)
      step("cnt_sat",  0, 6'b000001, 6'b000000, 0, 0, 0,   6'b000001, 6'b000000, 5'b00000, 0,
           (9 + i > 15) ? 4'hF : 4'(9 + i), (i >= 9), CA);
    step("sat_hold",   0, 6'b000000, 6'b000000, 0, 0, 1,   6'b000000, 6'b000000, 5'b00000, 0, 15, 1, CA);
    step("sat_clr",    0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 15, 0, CA);

    // two 7-cycle stalls separated by a gap never trip the watchdog
    for (int b = 0; b < 2; b++) begin
      for (int i = 1; i <= 7; i++)
        step("wd_short", 0, 6'b100000, 6'b000000, 0, 0, 0, 6'b111111, 6'b000000, 5'b00000, 0, 15, 0, CA);
      step("wd_gap",   0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 15, 0, CA);
    end
    step("wd_end",     0, 6'b000000, 6'b000000, 0, 0, 0,   6'b000000, 6'b000000, 5'b00000, 0, 15, 0, CA);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
- Parametrised pipeline stall/flush controller; successor to the fixed 6-stage core controller.
- Stage count is generic.
- Adds an oldest-wins redirect handshake, a fetch-drop state machine for squashing an in-flight instruction-bus fetch, a saturating stall-cycle counter and a stall-hang watchdog.
- Sits between all pipeline stages, the exception unit and the instruction-bus interface.

Parameters:
- NSTG, 6, number of stall domains; index 0 = pc/fetch, NSTG-1 = writeback (oldest).
- CNT_W, 32, width of the stall-cycle counter.
- HANG_CYC, 1024, consecutive stalled cycles before hang_o asserts; must be ≥2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- stallreq_i  in  NSTG  stage k requests stall of itself and all younger stages
- redir_req_i  in  NSTG  stage k requests redirect; level, held until acked
- redir_ack_o  out  NSTG  one-hot acceptance of a redirect request
- excp_flush_i  in  1  exception/interrupt flush; 1-cycle pulse
- if_busy_i  in  1  instruction-bus interface has a fetch in flight
- stall_o  out  NSTG  stall_o[j]: hold stage j
- flush_o  out  NSTG-1  flush_o[j]: clear pipeline register between stage j and j+1
- drop_o  out  1  fetch-drop state active; bus interface discards returning data
- stall_cnt_o  out  CNT_W  cycles with stall_o[0]=1, saturating
- hang_o  out  1  sticky watchdog flag
- hang_clr_i  in  1  clears hang_o and the watchdog counter

Behaviour:
- **Stall (combinational):** stall_o[j] = OR(stallreq_i[k], k≥j). Monotonic mask, no lookahead.
- **Redirect eligibility:** request k is eligible when redir_req_i[k]=1 and no stallreq_i[m] with m>k.
- **Redirect arbitration:** among eligible requests, the highest k wins; redir_ack_o[k]=1 for that k only, same cycle (combinational).
- **Redirect flush:** the winner drives flush_o[k-1:0]=1. A winner at k=0 flushes nothing.
- **Losing redirects:** younger requests get no ack; their stages are flushed and must drop the request.
- **Exception flush:** excp_flush_i=1 forces flush_o all-ones and redir_ack_o=0, overriding redirects. Stall still applies.
- **Fetch-drop FSM, states IDLE and DROP; reset → IDLE.**
  - IDLE→DROP when (a redirect is acked or excp_flush_i) and if_busy_i=1.
  - In DROP: drop_o=1 and flush_o[0] forced 1 (OR'ed with normal flush).
  - DROP→IDLE on the first cycle with if_busy_i=0. drop_o and the forced flush_o[0] still assert in that exit cycle.
  - A new redirect or exception while in DROP stays in DROP. Its flush_o is produced normally.
  - A flush event with if_busy_i=0 stays in IDLE; flush_o is single-cycle.
- **stall_cnt_o:** increments by 1 in every cycle with stall_o[0]=1. Saturates at all-ones, no wrap.
- **Watchdog counter:** increments in every cycle with any stall_o bit set; cleared on any cycle with stall_o=0.
  - When the counter reaches HANG_CYC-1 and stall persists, hang_o←1 on the next edge. hang_o is sticky.
  - The counter saturates at HANG_CYC-1.
  - hang_clr_i clears both hang_o and the counter. It has priority over increment in the same cycle.
- **Reset:** state→IDLE, stall_cnt_o=0, watchdog counter=0, hang_o=0, all synchronously.
  - During rst=1, drop_o=0 (the IDLE state is applied combinationally while rst is asserted, so no drop cycle is seen).
  - stall_o, flush_o and redir_ack_o follow their combinational equations.
  - Reset asserted mid-DROP returns to IDLE on that edge, regardless of if_busy_i.
- **Latency:** stall_o, flush_o and redir_ack_o have 0-cycle latency. drop_o, stall_cnt_o and hang_o are registered, 1 cycle.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - default NSTG;
  - stage index constants (STG_PC=0 … STG_WB=NSTG-1);
  - FSM state encoding (IDLE=1'b0, DROP=1'b1).
- One natural sub-module: pipe_prio_arb.
  - Parametrised highest-index-wins one-hot arbiter.
  - Used for redirect selection and reusable for the stall mask.
- Counters stay inline.

Test Plan:
- **Stall mask:** NSTG=6, stallreq_i=6'b000100 → stall_o=6'b000111. Then stallreq_i=6'b010001 → stall_o=6'b011111. Flush_o=0 throughout.
- **Redirect arbitration:** redir_req_i=6'b000110, stallreq_i=0 → redir_ack_o=6'b000100, flush_o=5'b00011. Repeat with stallreq_i=6'b001000 → redir_ack_o=0, flush_o=0; release stall → ack next cycle.
- **Exception priority:** excp_flush_i=1 with redir_req_i=6'b000100 → flush_o=5'b11111, redir_ack_o=0, drop_o stays 0 with if_busy_i=0.
- **Fetch drop:** redirect acked at cycle t with if_busy_i=1 held through t+3, low at t+4.
  - Required: drop_o=1 and flush_o[0]=1 for t+1..t+4.
  - drop_o=0 at t+5.
  - Assert rst at t+2 in a second run → drop_o=0 from t+3 onward (held at 0 during rst).
- **Counters:** stall_o[0]=1 for 10 cycles → stall_cnt_o=10. Preload via CNT_W=4 and stall 20 cycles → stall_cnt_o=4'hF.
- **Watchdog:** HANG_CYC=8, continuous stall 8 cycles → hang_o rises on the 8th edge and stays 1 after the stall ends. A hang_clr_i pulse → hang_o=0 next cycle. A stall of 7 cycles, then a gap, then 7 more → hang_o never asserts.
